alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 161 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequencer for an external 4-bit combinational ALU: accepts a command, reads a
// four-entry register file, runs one EXEC cycle, writes back and holds a response.
module alu_sequencer #(
    parameter logic [3:0] RF_INIT = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs1,
    input  logic [1:0] cmd_rs2,
    input  logic       cmd_imm_en,
    input  logic [3:0] cmd_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_carry,
    output logic [1:0] rsp_rd,
    output logic       carry_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    state_t          state_q, state_d;
    logic [3:0][3:0] rf_q, rf_d;
    logic [3:0]      alu_a_q, alu_a_d;
    logic [3:0]      alu_b_q, alu_b_d;
    logic [2:0]      alu_op_q, alu_op_d;
    logic [1:0]      rd_q, rd_d;
    logic [3:0]      rsp_data_q, rsp_data_d;
    logic            rsp_carry_q, rsp_carry_d;
    logic [1:0]      rsp_rd_q, rsp_rd_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            carry_flag_q, carry_flag_d;

    // The ALU carry is only meaningful for add and sub.
    function automatic logic carry_defined(input logic [2:0] op);
        carry_defined = (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Next-state and datapath: operands are latched on accept and cleared after EXEC.
    always_comb begin
        state_d      = state_q;
        rf_d         = rf_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rd_d         = rd_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_rd_d     = rsp_rd_q;
        rsp_valid_d  = rsp_valid_q;
        cmd_ready_d  = cmd_ready_q;
        carry_flag_d = carry_flag_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    alu_a_d     = rf_q[cmd_rs1];
                    alu_b_d     = cmd_imm_en ? cmd_imm : rf_q[cmd_rs2];
                    alu_op_d    = cmd_op;
                    rd_d        = cmd_rd;
                    cmd_ready_d = 1'b0;
                    state_d     = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rf_d[rd_q]  = alu_result;
                rsp_data_d  = alu_result;
                rsp_rd_d    = rd_q;
                rsp_valid_d = 1'b1;
                if (carry_defined(alu_op_q)) begin
                    rsp_carry_d  = alu_carry;
                    carry_flag_d = alu_carry;
                end else begin
                    rsp_carry_d = 1'b0;
                end
                alu_a_d  = 4'h0;
                alu_b_d  = 4'h0;
                alu_op_d = 3'b000;
                state_d  = RESP;
            end
            RESP: begin
                // cmd_ready rises only after the handshake edge, so no same-edge accept.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                alu_a_d     = 4'h0;
                alu_b_d     = 4'h0;
                alu_op_d    = 3'b000;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and register-file flops with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rf_q         <= {4{RF_INIT}};
            alu_a_q      <= 4'h0;
            alu_b_q      <= 4'h0;
            alu_op_q     <= 3'b000;
            rd_q         <= 2'd0;
            rsp_data_q   <= 4'h0;
            rsp_carry_q  <= 1'b0;
            rsp_rd_q     <= 2'd0;
            rsp_valid_q  <= 1'b0;
            cmd_ready_q  <= 1'b1;
            carry_flag_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_q         <= rf_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rd_q         <= rd_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_rd_q     <= rsp_rd_d;
            rsp_valid_q  <= rsp_valid_d;
            cmd_ready_q  <= cmd_ready_d;
            carry_flag_q <= carry_flag_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_rd     = rsp_rd_q;
    assign carry_flag = carry_flag_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; a small combinational ALU model closes the loop.
module tb_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic       cmd_imm_en;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic [1:0] rsp_rd;
    logic       carry_flag;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.RF_INIT(4'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rsp_rd     (rsp_rd),
        .carry_flag (carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; carry is deliberately 1 for ops where it is undefined.
    always_comb begin
        alu_result = 4'h0;
        alu_carry  = 1'b0;
        case (alu_op)
            3'b000:  {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  begin alu_result = alu_a & alu_b; alu_carry = 1'b1; end
            3'b011:  begin alu_result = alu_a | alu_b; alu_carry = 1'b1; end
            3'b100:  begin alu_result = alu_a ^ alu_b; alu_carry = 1'b1; end
            3'b101:  begin alu_result = ~alu_a; alu_carry = 1'b1; end
            3'b110:  begin alu_result = {alu_a[2:0], 1'b0}; alu_carry = 1'b1; end
            3'b111:  begin alu_result = {1'b0, alu_a[3:1]}; alu_carry = 1'b1; end
            default: begin alu_result = 4'h0; alu_carry = 1'b0; end
        endcase
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rsp_valid"},  4'(rsp_valid),  4'h0);
        check({tag, " rsp_data"},   rsp_data,       4'h0);
        check({tag, " rsp_carry"},  4'(rsp_carry),  4'h0);
        check({tag, " rsp_rd"},     4'(rsp_rd),     4'h0);
        check({tag, " carry_flag"}, 4'(carry_flag), 4'h0);
        check({tag, " alu_a"},      alu_a,          4'h0);
        check({tag, " alu_b"},      alu_b,          4'h0);
        check({tag, " alu_op"},     4'(alu_op),     4'h0);
    endtask

    // One full command at negedge granularity: accept, EXEC, RESP (optionally stalled), handshake.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2, input logic imm_en,
                           input logic [3:0] imm, input logic [3:0] exp_a, input logic [3:0] exp_b,
                           input logic [3:0] exp_data, input logic exp_carry, input logic exp_flag,
                           input int stall);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, 4'(cmd_ready), 4'h1);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_rd     = rd;
        cmd_rs1    = rs1;
        cmd_rs2    = rs2;
        cmd_imm_en = imm_en;
        cmd_imm    = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, " exec cmd_ready"}, 4'(cmd_ready), 4'h0);
        check({tag, " exec rsp_valid"}, 4'(rsp_valid), 4'h0);
        check({tag, " exec alu_a"},     alu_a,         exp_a);
        check({tag, " exec alu_b"},     alu_b,         exp_b);
        check({tag, " exec alu_op"},    4'(alu_op),    4'(op));
        @(negedge clk);
        check({tag, " rsp_valid"},  4'(rsp_valid),  4'h1);
        check({tag, " rsp_data"},   rsp_data,       exp_data);
        check({tag, " rsp_carry"},  4'(rsp_carry),  4'(exp_carry));
        check({tag, " rsp_rd"},     4'(rsp_rd),     4'(rd));
        check({tag, " carry_flag"}, 4'(carry_flag), 4'(exp_flag));
        check({tag, " resp alu_a"}, alu_a,          4'h0);
        check({tag, " resp alu_op"}, 4'(alu_op),    4'h0);
        for (int i = 0; i < stall; i++) begin
            rsp_ready  = 1'b0;
            cmd_valid  = 1'b1;
            cmd_op     = 3'b000;
            cmd_rd     = 2'd3;
            cmd_rs1    = 2'd0;
            cmd_imm_en = 1'b1;
            cmd_imm    = 4'hF;
            @(negedge clk);
            check({tag, " stall rsp_valid"}, 4'(rsp_valid), 4'h1);
            check({tag, " stall rsp_data"},  rsp_data,      exp_data);
            check({tag, " stall rsp_carry"}, 4'(rsp_carry), 4'(exp_carry));
            check({tag, " stall rsp_rd"},    4'(rsp_rd),    4'(rd));
            check({tag, " stall cmd_ready"}, 4'(cmd_ready), 4'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check({tag, " done rsp_valid"}, 4'(rsp_valid), 4'h0);
        check({tag, " done cmd_ready"}, 4'(cmd_ready), 4'h1);
        check({tag, " done alu_op"},    4'(alu_op),    4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 3'b000;
        cmd_rd     = 2'd0;
        cmd_rs1    = 2'd0;
        cmd_rs2    = 2'd0;
        cmd_imm_en = 1'b0;
        cmd_imm    = 4'h0;
        rsp_ready  = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset cmd_ready", 4'(cmd_ready), 4'h1);

        // name, op, rd, rs1, rs2, imm_en, imm, exp_a, exp_b, exp_data, exp_carry, exp_flag, stall
        run_cmd("load r1",   3'b011, 2'd1, 2'd0, 2'd0, 1'b1, 4'h9, 4'h0, 4'h9, 4'h9, 1'b0, 1'b0, 0);
        run_cmd("load r2",   3'b011, 2'd2, 2'd0, 2'd0, 1'b1, 4'h9, 4'h0, 4'h9, 4'h9, 1'b0, 1'b0, 0);
        run_cmd("add carry", 3'b000, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 4'h9, 4'h9, 4'h2, 1'b1, 1'b1, 0);
        run_cmd("read r3",   3'b011, 2'd0, 2'd3, 2'd0, 1'b1, 4'h0, 4'h2, 4'h0, 4'h2, 1'b0, 1'b1, 0);
        run_cmd("load r1 3", 3'b011, 2'd1, 2'd0, 2'd0, 1'b1, 4'h3, 4'h2, 4'h3, 4'h3, 1'b0, 1'b1, 0);
        run_cmd("sub borrow", 3'b001, 2'd0, 2'd1, 2'd0, 1'b1, 4'h5, 4'h3, 4'h5, 4'hE, 1'b1, 1'b1, 0);
        run_cmd("xor sticky", 3'b100, 2'd2, 2'd1, 2'd0, 1'b1, 4'h6, 4'h3, 4'h6, 4'h5, 1'b0, 1'b1, 0);
        run_cmd("add clear", 3'b000, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 4'h3, 4'h5, 4'h8, 1'b0, 1'b0, 0);
        run_cmd("sub noborrow", 3'b001, 2'd3, 2'd3, 2'd2, 1'b0, 4'h0, 4'h8, 4'h5, 4'h3, 1'b0, 1'b0, 0);
        run_cmd("backpressure", 3'b010, 2'd1, 2'd0, 2'd0, 1'b1, 4'hC, 4'hE, 4'hC, 4'hC, 1'b0, 1'b0, 3);
        run_cmd("load r1 9", 3'b100, 2'd1, 2'd1, 2'd0, 1'b1, 4'h5, 4'hC, 4'h5, 4'h9, 1'b0, 1'b0, 0);
        run_cmd("shl raw",   3'b110, 2'd1, 2'd1, 2'd0, 1'b0, 4'h0, 4'h9, 4'hE, 4'h2, 1'b0, 1'b0, 0);
        run_cmd("shr raw",   3'b111, 2'd1, 2'd1, 2'd0, 1'b0, 4'h0, 4'h2, 4'hE, 4'h1, 1'b0, 1'b0, 0);
        run_cmd("not a",     3'b101, 2'd2, 2'd0, 2'd0, 1'b0, 4'h0, 4'hE, 4'hE, 4'h1, 1'b0, 1'b0, 0);
        run_cmd("add r0 r0", 3'b000, 2'd3, 2'd0, 2'd0, 1'b0, 4'h0, 4'hE, 4'hE, 4'hC, 1'b1, 1'b1, 0);

        // Reset asserted mid-EXEC of add rd=2: nothing written, no response.
        cmd_valid  = 1'b1;
        cmd_op     = 3'b000;
        cmd_rd     = 2'd2;
        cmd_rs1    = 2'd2;
        cmd_rs2    = 2'd3;
        cmd_imm_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midexec alu_a", alu_a, 4'h1);
        check("midexec alu_b", alu_b, 4'hC);
        check("midexec carry_flag", 4'(carry_flag), 4'h1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midexec reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post midexec cmd_ready", 4'(cmd_ready), 4'h1);
        check("post midexec rsp_valid", 4'(rsp_valid), 4'h0);
        run_cmd("r2 init",   3'b011, 2'd0, 2'd2, 2'd0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 0);
        run_cmd("r3 init",   3'b011, 2'd0, 2'd3, 2'd0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
